// File: rtl/i8035_xbus.sv
// External-bus demultiplexer for the I8035 sound CPU: latches the multiplexed
// address on ALE, serves PSEN/RD cycles from two synchronous ROMs, and exposes MOVX writes.
module i8035_xbus #(
  parameter int PROM_AW = 12,
  parameter int XROM_AW = 11
) (
  input  logic               I_CLK,
  input  logic               I_RSTn,
  input  logic               I_ALE,
  input  logic               I_PSENn,
  input  logic               I_RDn,
  input  logic               I_WRn,
  input  logic [7:0]         I_DB,
  input  logic [7:0]         I_P2,
  output logic [7:0]         O_DB,
  output logic [PROM_AW-1:0] O_PROM_A,
  input  logic [7:0]         I_PROM_D,
  output logic [XROM_AW-1:0] O_XROM_A,
  input  logic [7:0]         I_XROM_D,
  output logic [7:0]         O_XWR_A,
  output logic [7:0]         O_XWR_D,
  output logic               O_XWR_STB,
  output logic               O_ERR,
  output logic [2:0]         O_DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_PF_WAIT = 3'd2,
    S_PF_HOLD = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_HOLD = 3'd5,
    S_WR      = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic       ale_q, ale_d;
  logic [7:0] db_q, db_d;
  logic [7:0] p2_q, p2_d;
  logic [7:0] a_q, a_d;
  logic [7:0] p2l_q, p2l_d;
  logic [7:0] odb_q, odb_d;
  logic [7:0] xwr_a_q, xwr_a_d;
  logic [7:0] xwr_d_q, xwr_d_d;
  logic       stb_q, stb_d;
  logic       err_q, err_d;

  logic        ale_fall;
  logic [1:0]  n_low;
  logic [11:0] prom_full;
  logic [15:0] xrom_full;

  assign ale_fall  = ale_q & ~I_ALE;
  assign n_low     = {1'b0, ~I_PSENn} + {1'b0, ~I_RDn} + {1'b0, ~I_WRn};
  assign prom_full = {p2l_q[3:0], a_q};
  assign xrom_full = {p2l_q, a_q};

  always_comb begin
    state_d = state_q;
    ale_d   = I_ALE;
    db_d    = I_DB;
    p2_d    = I_P2;
    a_d     = a_q;
    p2l_d   = p2l_q;
    odb_d   = odb_q;
    xwr_a_d = xwr_a_q;
    xwr_d_d = xwr_d_q;
    stb_d   = 1'b0;
    err_d   = err_q;

    // The latch is independent of the FSM so an ALE that aborts a cycle still captures.
    if (ale_fall) begin
      a_d   = db_q;
      p2l_d = p2_q;
    end

    if (n_low >= 2'd2) err_d = 1'b1;

    if (I_ALE && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      odb_d   = 8'hFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ale_fall) state_d = S_ADDR;
        end
        S_ADDR: begin
          if (!I_PSENn) begin
            state_d = S_PF_WAIT;
          end else if (!I_RDn) begin
            state_d = S_RD_WAIT;
          end else if (!I_WRn) begin
            state_d = S_WR;
            xwr_d_d = I_DB;
          end
        end
        S_PF_WAIT: begin
          if (I_PSENn) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PF_HOLD;
            odb_d   = I_PROM_D;
          end
        end
        S_PF_HOLD: begin
          if (I_PSENn) begin
            state_d = S_IDLE;
            odb_d   = 8'hFF;
          end
        end
        S_RD_WAIT: begin
          if (I_RDn) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_HOLD;
            odb_d   = I_XROM_D;
          end
        end
        S_RD_HOLD: begin
          if (I_RDn) begin
            state_d = S_IDLE;
            odb_d   = 8'hFF;
          end
        end
        S_WR: begin
          // O_XWR_STB is a single-cycle qualifier: O_XWR_A/O_XWR_D are valid while it is high.
          if (!I_WRn) begin
            xwr_d_d = I_DB;
          end else begin
            state_d = S_IDLE;
            stb_d   = 1'b1;
            xwr_a_d = a_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          odb_d   = 8'hFF;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= S_IDLE;
      ale_q   <= 1'b0;
      db_q    <= 8'h00;
      p2_q    <= 8'h00;
      a_q     <= 8'h00;
      p2l_q   <= 8'h00;
      odb_q   <= 8'hFF;
      xwr_a_q <= 8'h00;
      xwr_d_q <= 8'h00;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ale_q   <= ale_d;
      db_q    <= db_d;
      p2_q    <= p2_d;
      a_q     <= a_d;
      p2l_q   <= p2l_d;
      odb_q   <= odb_d;
      xwr_a_q <= xwr_a_d;
      xwr_d_q <= xwr_d_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign O_DB        = odb_q;
  assign O_PROM_A    = prom_full[PROM_AW-1:0];
  assign O_XROM_A    = xrom_full[XROM_AW-1:0];
  assign O_XWR_A     = xwr_a_q;
  assign O_XWR_D     = xwr_d_q;
  assign O_XWR_STB   = stb_q;
  assign O_ERR       = err_q;
  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_i8035_xbus.sv
// Bench for i8035_xbus: directed bus cycles plus randomized fetch/read/write
// transactions checked against a cycle-level model of the bus protocol.
module tb_i8035_xbus;
  localparam int PROM_AW = 12;
  localparam int XROM_AW = 11;

  // clock / reset
  logic I_CLK = 1'b0;
  logic I_RSTn = 1'b0;
  always #5 I_CLK = ~I_CLK;

  logic               I_ALE = 1'b0, I_PSENn = 1'b1, I_RDn = 1'b1, I_WRn = 1'b1;
  logic [7:0]         I_DB = 8'h00, I_P2 = 8'h00;
  logic [7:0]         O_DB, I_PROM_D, I_XROM_D, O_XWR_A, O_XWR_D;
  logic [PROM_AW-1:0] O_PROM_A;
  logic [XROM_AW-1:0] O_XROM_A;
  logic               O_XWR_STB, O_ERR;
  logic [2:0]         O_DBG_STATE;

  i8035_xbus #(.PROM_AW(PROM_AW), .XROM_AW(XROM_AW)) dut (
    .I_CLK(I_CLK), .I_RSTn(I_RSTn), .I_ALE(I_ALE), .I_PSENn(I_PSENn),
    .I_RDn(I_RDn), .I_WRn(I_WRn), .I_DB(I_DB), .I_P2(I_P2), .O_DB(O_DB),
    .O_PROM_A(O_PROM_A), .I_PROM_D(I_PROM_D), .O_XROM_A(O_XROM_A),
    .I_XROM_D(I_XROM_D), .O_XWR_A(O_XWR_A), .O_XWR_D(O_XWR_D),
    .O_XWR_STB(O_XWR_STB), .O_ERR(O_ERR), .O_DBG_STATE(O_DBG_STATE)
  );

  // synchronous ROMs with one cycle of latency
  logic [7:0] prom [0:(1<<PROM_AW)-1];
  logic [7:0] xrom [0:(1<<XROM_AW)-1];
  always @(posedge I_CLK) begin
    I_PROM_D <= prom[O_PROM_A];
    I_XROM_D <= xrom[O_XROM_A];
  end

  // reference model state
  int         n_checks = 0;
  int         n_errors = 0;
  logic       err_exp = 1'b0;
  logic [7:0] cur_a = 8'h00;
  logic [7:0] cur_p2 = 8'h00;
  logic [7:0] wr_exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int prom_addr(input logic [7:0] a, input logic [7:0] p2);
    return (int'(p2) * 256 + int'(a)) % (1 << PROM_AW);
  endfunction

  function automatic int xrom_addr(input logic [7:0] a, input logic [7:0] p2);
    return (int'(p2) * 256 + int'(a)) % (1 << XROM_AW);
  endfunction

  // driver tasks: each starts just after a falling edge and ends on one
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      I_DB = 8'($urandom);
      @(negedge I_CLK);
      check("idle_db", O_DB, 8'hFF);
      check("idle_stb", O_XWR_STB, 1'b0);
      check("idle_err", O_ERR, err_exp);
    end
  endtask

  task automatic ale_high(input logic [7:0] a, input logic [7:0] p2);
    I_ALE = 1'b1; I_DB = a; I_P2 = p2;
    cur_a = a; cur_p2 = p2;
    @(negedge I_CLK);
    check("ale_db", O_DB, 8'hFF);
  endtask

  task automatic ale_low();
    I_ALE = 1'b0; I_DB = 8'($urandom); I_P2 = 8'($urandom);
    @(negedge I_CLK);
    check("prom_a", 32'(O_PROM_A), 32'(prom_addr(cur_a, cur_p2)));
    check("xrom_a", 32'(O_XROM_A), 32'(xrom_addr(cur_a, cur_p2)));
    check("addr_db", O_DB, 8'hFF);
    check("addr_stb", O_XWR_STB, 1'b0);
  endtask

  // lows: bit0 = PSENn low, bit1 = RDn low; data is valid from the 2nd low-sampled edge
  task automatic strobe_read(input logic [1:0] lows, input int len, input logic [7:0] exp);
    I_PSENn = ~lows[0]; I_RDn = ~lows[1];
    if (lows == 2'b11) err_exp = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge I_CLK);
      check("rd_db", O_DB, (i >= 2) ? exp : 8'hFF);
      check("rd_err", O_ERR, err_exp);
      I_DB = 8'($urandom);
    end
    I_PSENn = 1'b1; I_RDn = 1'b1;
    @(negedge I_CLK);
    check("rd_end_db", O_DB, 8'hFF);
    check("rd_end_err", O_ERR, err_exp);
  endtask

  task automatic strobe_write(input int len, input logic [7:0] data);
    I_WRn = 1'b0; I_DB = data;
    wr_exp_q.push_back(data);
    for (int i = 1; i <= len; i++) begin
      @(negedge I_CLK);
      check("wr_busy_stb", O_XWR_STB, 1'b0);
      check("wr_busy_db", O_DB, 8'hFF);
    end
    I_WRn = 1'b1;
    @(negedge I_CLK);
    check("wr_stb", O_XWR_STB, 1'b1);
    check("wr_a", O_XWR_A, cur_a);
    check("wr_d", O_XWR_D, wr_exp_q.pop_front());
    check("wr_db", O_DB, 8'hFF);
    I_DB = 8'($urandom);
    @(negedge I_CLK);
    check("wr_stb_off", O_XWR_STB, 1'b0);
  endtask

  task automatic pulse_reset();
    I_RSTn = 1'b0;
    @(negedge I_CLK);
    I_RSTn = 1'b1;
    err_exp = 1'b0;
  endtask

  initial begin
    logic [7:0] a, p2, d;
    int kind, len;

    for (int i = 0; i < (1 << PROM_AW); i++) prom[i] = 8'($urandom);
    for (int i = 0; i < (1 << XROM_AW); i++) xrom[i] = 8'($urandom);
    prom[12'h53C] = 8'hA7;
    xrom[11'h7FF] = 8'h12;

    repeat (2) @(negedge I_CLK);
    check("rst_db", O_DB, 8'hFF);
    check("rst_stb", O_XWR_STB, 1'b0);
    check("rst_xwr_a", O_XWR_A, 8'h00);
    check("rst_xwr_d", O_XWR_D, 8'h00);
    check("rst_err", O_ERR, 1'b0);
    check("rst_prom_a", 32'(O_PROM_A), 32'h0);
    I_RSTn = 1'b1;
    idle(2);

    // program fetch
    ale_high(8'h3C, 8'h05);
    ale_low();
    check("fetch_prom_a", 32'(O_PROM_A), 32'h53C);
    strobe_read(2'b01, 6, 8'hA7);
    idle(1);

    // MOVX read with full-width address
    ale_high(8'hFF, 8'h07);
    ale_low();
    check("movx_xrom_a", 32'(O_XROM_A), 32'h7FF);
    strobe_read(2'b10, 4, 8'h12);

    // MOVX write
    ale_high(8'h40, 8'h00);
    ale_low();
    strobe_write(3, 8'h99);

    // short strobe, then a normal fetch
    ale_high(8'h81, 8'h02);
    ale_low();
    strobe_read(2'b01, 1, 8'h00);
    ale_high(8'h5A, 8'h0C);
    ale_low();
    strobe_read(2'b01, 3, prom[prom_addr(8'h5A, 8'h0C)]);

    // ALE during a write aborts it without a strobe; the new address is latched
    ale_high(8'h11, 8'h00);
    ale_low();
    I_WRn = 1'b0; I_DB = 8'h55;
    repeat (2) @(negedge I_CLK);
    I_WRn = 1'b1; I_ALE = 1'b1; I_DB = 8'h22; I_P2 = 8'h03;
    cur_a = 8'h22; cur_p2 = 8'h03;
    @(negedge I_CLK);
    check("wr_abort_stb", O_XWR_STB, 1'b0);
    ale_low();
    check("wr_abort_stb2", O_XWR_STB, 1'b0);
    strobe_read(2'b01, 3, prom[prom_addr(8'h22, 8'h03)]);

    // PSENn and RDn together: error flag, PROM wins, sticky until reset
    ale_high(8'h3C, 8'h05);
    ale_low();
    strobe_read(2'b11, 4, 8'hA7);
    idle(2);
    pulse_reset();
    @(negedge I_CLK);
    check("err_cleared", O_ERR, 1'b0);

    // reset while holding MOVX read data
    ale_high(8'hFF, 8'h07);
    ale_low();
    I_RDn = 1'b0;
    repeat (3) @(negedge I_CLK);
    check("hold_db", O_DB, 8'h12);
    #2 I_RSTn = 1'b0;
    #1;
    check("async_rst_db", O_DB, 8'hFF);
    check("async_rst_stb", O_XWR_STB, 1'b0);
    check("async_rst_xwr_a", O_XWR_A, 8'h00);
    @(negedge I_CLK);
    I_RSTn = 1'b1; I_RDn = 1'b1; err_exp = 1'b0;
    idle(1);
    ale_high(8'h3C, 8'h05);
    ale_low();
    strobe_read(2'b01, 4, 8'hA7);

    // randomized transactions
    for (int t = 0; t < 80; t++) begin
      a = 8'($urandom); p2 = 8'($urandom); d = 8'($urandom);
      kind = $urandom_range(0, 2);
      len = $urandom_range(1, 5);
      ale_high(a, p2);
      ale_low();
      case (kind)
        0: strobe_read(2'b01, len, prom[prom_addr(a, p2)]);
        1: strobe_read(2'b10, len, xrom[xrom_addr(a, p2)]);
        default: strobe_write(len, d);
      endcase
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i8035_xbus.md
Name: i8035_xbus

Overview:
External-bus demultiplexer for the sound CPU, sitting directly downstream of the I8035IP wrapper. It consumes the core's multiplexed bus (O_ALE, O_PSENn, O_RDn, O_WRn, O_DB, O_P2) and serves three bus cycles:
- program fetch from the external program ROM (PSEN cycles);
- MOVX reads from the sample/data ROM (RD cycles);
- MOVX writes, which it exposes as a strobed write port (WR cycles).
It drives the core's I_DB and returns 8'hFF whenever no device drives the bus.

Parameters:
PROM_AW, 12, program ROM address width (bits); address = {P2[3:0], A[7:0]} truncated to PROM_AW.
XROM_AW, 11, data ROM address width; address = {latched P2, A[7:0]} truncated to XROM_AW.

Ports:
I_CLK  in  1  system clock; the same clock that feeds I8035IP.
I_RSTn  in  1  asynchronous active-low reset.
I_ALE  in  1  from core O_ALE.
I_PSENn  in  1  from core O_PSENn.
I_RDn  in  1  from core O_RDn.
I_WRn  in  1  from core O_WRn.
I_DB  in  8  from core O_DB.
I_P2  in  8  from core O_P2.
O_DB  out  8  to core I_DB (read data, or 8'hFF when idle).
O_PROM_A  out  PROM_AW  program ROM address.
I_PROM_D  in  8  program ROM data; synchronous, 1-cycle latency.
O_XROM_A  out  XROM_AW  data ROM address.
I_XROM_D  in  8  data ROM data; synchronous, 1-cycle latency.
O_XWR_A  out  8  write address (A[7:0]).
O_XWR_D  out  8  write data.
O_XWR_STB  out  1  one-cycle write strobe.
O_ERR  out  1  sticky protocol-error flag.

Behaviour:
Reset (asynchronous, I_RSTn=0):
- state=IDLE; address latch=0; O_DB=8'hFF; O_XWR_STB=0; O_XWR_A=0; O_XWR_D=0; O_ERR=0.
- Every strobe state is left immediately on reset assertion, including reset mid-cycle.

Input sampling: I_ALE, I_DB and I_P2 are registered once (ale_d, db_d, p2_d).

Address latch:
- The latch fires when ale_d=1 and I_ALE=0 (ALE falling edge).
- On that cycle: A[7:0] <= db_d and P2L <= p2_d.
- O_PROM_A and O_XROM_A are combinational from {P2L, A}.

States: IDLE, ADDR, PF_WAIT, PF_HOLD, RD_WAIT, RD_HOLD, WR.
- IDLE -> ADDR on the ALE falling edge.
- ADDR -> PF_WAIT if I_PSENn=0.
- ADDR -> RD_WAIT if I_RDn=0 (PSENn high).
- ADDR -> WR if I_WRn=0.
- ADDR with no strobe: stay.
- PF_WAIT -> PF_HOLD after 1 cycle. On entry to PF_HOLD, O_DB <= I_PROM_D.
- RD_WAIT -> RD_HOLD after 1 cycle. On entry to RD_HOLD, O_DB <= I_XROM_D.
- In either HOLD state, O_DB is held stable until the strobe rises; then O_DB <= 8'hFF and state -> IDLE.
- Read latency: O_DB is valid 2 clocks after the strobe is seen low.
- WR: O_XWR_D <= I_DB every cycle while I_WRn=0. When I_WRn rises:
  - O_XWR_STB=1 for exactly one cycle;
  - O_XWR_A=A;
  - state -> IDLE.
- A strobe that rises during a WAIT state aborts the cycle: O_DB stays 8'hFF and state -> IDLE.

Boundary conditions:
- I_ALE=1 in any non-IDLE state: abort to IDLE, force O_DB=8'hFF, produce no write strobe. The same cycle's ALE fall is still latched normally.
- More than one of PSENn, RDn, WRn low together: set O_ERR=1 (sticky until reset). Priority is PSEN > RD > WR.
- Address wrap: the high bits above PROM_AW/XROM_AW are discarded; there is no bank-overflow detection.
- O_DB is only ever ROM data or 8'hFF; it never reflects I_DB.

Test Plan:
- Fetch: ALE high with DB=8'h3C, P2=8'h05, then ALE falls; PSENn low 6 clocks with PROM[0x53C]=8'hA7 -> O_PROM_A=12'h53C, O_DB=8'hA7 from the 2nd clock after PSENn falls until PSENn rises, then 8'hFF.
- MOVX read: ALE latches DB=8'hFF, P2=8'h07; RDn low with XROM[0x7FF]=8'h12 -> O_XROM_A=11'h7FF, O_DB=8'h12 two clocks later, 8'hFF after RDn rises.
- MOVX write: ALE latches 8'h40; WRn low with DB=8'h99 -> one O_XWR_STB pulse on WRn rise with O_XWR_A=8'h40, O_XWR_D=8'h99; no O_DB change.
- Short strobe: PSENn low for 1 clock only -> no data driven, O_DB stays 8'hFF, state returns to IDLE, next ALE latches correctly.
- Error and priority: PSENn and RDn low together -> O_ERR=1 and PROM data served; O_ERR stays 1 after strobes release; reset clears it.
- Reset mid-RD_HOLD: I_RSTn low for 1 clock -> O_DB=8'hFF and O_XWR_STB=0 immediately; the next full fetch cycle completes normally.
